// File: rtl/line_bus_bridge.sv
// rtl/line_bus_bridge.sv - moves one cache line to/from a word bus as a burst of word beats
// Reads overlap issue and return; the assembled line is presented with a single-cycle ack.
module line_bus_bridge #(
  parameter int addr_width = 32,
  parameter int line_width = 256,
  parameter int word_width = 32,
  parameter int beats      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_width-1:0] line_addr,
  input  logic                  line_cs,
  input  logic                  line_we,
  input  logic [line_width-1:0] line_data_i,
  output logic                  line_ack,
  output logic [line_width-1:0] line_data_o,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [addr_width-1:0] bus_addr,
  output logic [word_width-1:0] bus_wdata,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [word_width-1:0] bus_rdata
);

  localparam int idx_w = $clog2(beats);
  localparam int cnt_w = idx_w + 1;
  localparam int boff  = $clog2(line_width / 8);
  localparam int woff  = $clog2(word_width / 8);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(beats - 1);
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(beats);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_ACK, S_DONE} state_t;

  state_t                state;
  logic [addr_width-1:0] base;
  logic [line_width-1:0] wbuf;
  logic [line_width-1:0] rbuf;
  logic [line_width-1:0] rbuf_next;
  logic [cnt_w-1:0]      issue_cnt;
  logic [cnt_w-1:0]      recv_cnt;
  logic [cnt_w-1:0]      issue_inc;
  logic [cnt_w-1:0]      recv_inc;
  logic                  accept;
  logic                  take;

  function automatic logic [addr_width-1:0] line_base(input logic [addr_width-1:0] a);
    return {a[addr_width-1:boff], {boff{1'b0}}};
  endfunction

  function automatic logic [addr_width-1:0] beat_addr(input logic [addr_width-1:0] b,
                                                      input logic [cnt_w-1:0] cnt);
    return {b[addr_width-1:boff], cnt[idx_w-1:0], {woff{1'b0}}};
  endfunction

  assign accept    = bus_req & bus_gnt;
  assign take      = (state == S_READ) & bus_rvalid & (recv_cnt < full_cnt);
  assign issue_inc = issue_cnt + 1'b1;
  assign recv_inc  = recv_cnt + 1'b1;

  // Folds the returning word in so the final beat lands in line_data_o on the same edge.
  always_comb begin
    rbuf_next = rbuf;
    if (take) rbuf_next[int'(recv_cnt[idx_w-1:0]) * word_width +: word_width] = bus_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      line_ack    <= 1'b0;
      line_data_o <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      base        <= '0;
      wbuf        <= '0;
      rbuf        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (line_cs) begin
            base      <= line_base(line_addr);
            wbuf      <= line_data_i;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            bus_req   <= 1'b1;
            bus_we    <= line_we;
            bus_addr  <= beat_addr(line_base(line_addr), '0);
            bus_wdata <= line_we ? line_data_i[word_width-1:0] : '0;
            state     <= line_we ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (accept) begin
            issue_cnt <= issue_inc;
            if (issue_cnt == last_cnt) begin
              bus_req  <= 1'b0;
              bus_we   <= 1'b0;
              line_ack <= 1'b1;
              state    <= S_ACK;
            end else begin
              bus_addr  <= beat_addr(base, issue_inc);
              bus_wdata <= wbuf[int'(issue_inc[idx_w-1:0]) * word_width +: word_width];
            end
          end
        end
        S_READ: begin
          if (accept) begin
            issue_cnt <= issue_inc;
            if (issue_cnt == last_cnt) bus_req <= 1'b0;
            else bus_addr <= beat_addr(base, issue_inc);
          end
          if (take) begin
            rbuf     <= rbuf_next;
            recv_cnt <= recv_inc;
            if (recv_cnt == last_cnt) begin
              line_data_o <= rbuf_next;
              line_ack    <= 1'b1;
              bus_req     <= 1'b0;
              state       <= S_ACK;
            end
          end
        end
        S_ACK: begin
          line_ack <= 1'b0;
          state    <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_bus_bridge.sv
// tb/tb_line_bus_bridge.sv - directed bench for line_bus_bridge with a small word-bus model
// Cycle numbers count the cycle in which line_cs is first raised as cycle 1.
module tb_line_bus_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_addr;
  logic         line_cs;
  logic         line_we;
  logic [255:0] line_data_i;
  logic         line_ack;
  logic [255:0] line_data_o;
  logic         bus_req;
  logic         bus_we;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic         bus_gnt;
  logic         bus_rvalid;
  logic [31:0]  bus_rdata;

  int total = 0;
  int bad   = 0;

  line_bus_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .line_addr  (line_addr),
    .line_cs    (line_cs),
    .line_we    (line_we),
    .line_data_i(line_data_i),
    .line_ack   (line_ack),
    .line_data_o(line_data_o),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // gmode 0: gnt always 1; gmode 1: gnt 1,0,1,0... Read data returns rd cycles after its gnt, rdata = address.
  task automatic xfer(input logic [31:0] a, input logic we, input logic [255:0] d,
                      input int gmode, input int rd,
                      output int ack_cyc, output int nbeats, output int nrv,
                      output int extra, output logic [255:0] dout);
    int          q_due[$];
    logic [31:0] q_addr[$];
    logic [31:0] base;
    int          c;
    base    = {a[31:5], 5'b0};
    ack_cyc = 0;
    nbeats  = 0;
    nrv     = 0;
    extra   = 0;
    dout    = '0;
    c       = 0;
    line_addr   = a;
    line_we     = we;
    line_data_i = d;
    line_cs     = 1'b1;
    bus_gnt     = 1'b0;
    bus_rvalid  = 1'b0;
    while (ack_cyc == 0 && c < 80) begin
      @(negedge clk);
      c++;
      if (line_ack) begin
        ack_cyc = c + 1;
        dout    = line_data_o;
      end else begin
        if (bus_req) begin
          if (nbeats >= 8) extra++;
          else begin
            chk("beat_addr", bus_addr, base + 32'(4 * nbeats));
            chk("beat_we", bus_we, we);
            if (we) chk("beat_wdata", bus_wdata, d[nbeats*32 +: 32]);
          end
        end
        bus_gnt = (gmode == 1) ? ((c % 2) == 1) : 1'b1;
        if (bus_req && bus_gnt) begin
          q_due.push_back(c + rd);
          q_addr.push_back(bus_addr);
          nbeats++;
        end
        if (!we && q_due.size() > 0 && q_due[0] <= c) begin
          void'(q_due.pop_front());
          bus_rdata  = q_addr.pop_front();
          bus_rvalid = 1'b1;
          nrv++;
        end else begin
          bus_rvalid = 1'b0;
        end
      end
    end
    line_cs    = 1'b0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    chk("xfer_ack_seen", (ack_cyc != 0), 1'b1);
    @(negedge clk);
    chk("ack_one_cycle", line_ack, 1'b0);
    @(negedge clk);
  endtask

  logic [255:0] wd;
  logic [255:0] exp_line;
  logic [255:0] dout;
  logic [255:0] keep_line;
  int           ack_cyc, nb, nrv, extra, n_ack, ack_at;
  logic         req10, req11;

  initial begin
    rst = 1'b0; line_cs = 1'b0; line_we = 1'b0; line_addr = '0; line_data_i = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", line_ack, 1'b0);
    chk("rst_req", bus_req, 1'b0);
    chk("rst_we", bus_we, 1'b0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_data_o", line_data_o, 256'h0);
    rst = 1'b1;
    @(negedge clk);

    // 1: plain write-back, offset bits of the address dropped
    for (int k = 0; k < 8; k++) wd[k*32 +: 32] = 32'hA0 + 32'(k);
    xfer(32'h0000_1234, 1'b1, wd, 0, 1, ack_cyc, nb, nrv, extra, dout);
    chk("t1_ack_cycle", ack_cyc, 10);
    chk("t1_beats", nb, 8);
    chk("t1_extra_req", extra, 0);

    // 2: refill with one-cycle return
    for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = 32'h40 + 32'(4 * k);
    xfer(32'h0000_0040, 1'b0, '0, 0, 1, ack_cyc, nb, nrv, extra, dout);
    chk("t2_ack_cycle", ack_cyc, 11);
    chk("t2_line", dout, exp_line);
    chk("t2_rvalids", nrv, 8);
    chk("t2_extra_req", extra, 0);
    keep_line = exp_line;

    // 3: write with gnt toggling; stalled beats checked inside xfer
    for (int k = 0; k < 8; k++) wd[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
    xfer(32'h0000_1000, 1'b1, wd, 1, 1, ack_cyc, nb, nrv, extra, dout);
    chk("t3_ack_cycle", ack_cyc, 17);
    chk("t3_beats", nb, 8);
    chk("t3_extra_req", extra, 0);
    chk("t3_refill_held", line_data_o, keep_line);

    // 4: all gnts first, returns 5 cycles late
    for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = 32'h5A0 + 32'(4 * k);
    xfer(32'h0000_05A0, 1'b0, '0, 0, 5, ack_cyc, nb, nrv, extra, dout);
    chk("t4_ack_cycle", ack_cyc, 15);
    chk("t4_line", dout, exp_line);
    chk("t4_beats", nb, 8);
    chk("t4_extra_req", extra, 0);

    // 5: reset in the middle of a read, then stray returns
    line_addr = 32'h200; line_we = 1'b0; line_cs = 1'b1; bus_gnt = 1'b1; bus_rvalid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t5_beat3_addr", bus_addr, 32'h20C);
    rst = 1'b0;
    #1;
    chk("t5_rst_req", bus_req, 1'b0);
    chk("t5_rst_addr", bus_addr, 32'h0);
    chk("t5_rst_data_o", line_data_o, 256'h0);
    chk("t5_rst_ack", line_ack, 1'b0);
    @(negedge clk);
    rst = 1'b1; line_cs = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t5_stray_ack", line_ack, 1'b0);
    chk("t5_stray_req", bus_req, 1'b0);
    @(negedge clk);
    chk("t5_stray_ack2", line_ack, 1'b0);
    bus_rvalid = 1'b0;
    for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = 32'h300 + 32'(4 * k);
    xfer(32'h0000_0300, 1'b0, '0, 0, 1, ack_cyc, nb, nrv, extra, dout);
    chk("t5_after_ack_cycle", ack_cyc, 11);
    chk("t5_after_line", dout, exp_line);

    // 6: cs held high through ACK and DONE
    line_addr = 32'h80; line_we = 1'b1; line_data_i = wd; line_cs = 1'b1;
    bus_gnt = 1'b1; bus_rvalid = 1'b0;
    n_ack = 0; ack_at = 0; req10 = 1'b1; req11 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (line_ack) begin
        n_ack++;
        if (ack_at == 0) ack_at = c;
      end
      if (c == 10) req10 = bus_req;
      if (c == 11) req11 = bus_req;
    end
    chk("t6_ack_count", n_ack, 1);
    chk("t6_ack_at", ack_at, 9);
    chk("t6_done_req", req10, 1'b0);
    chk("t6_idle_req", req11, 1'b0);
    chk("t6_restart_req", bus_req, 1'b1);
    chk("t6_restart_addr", bus_addr, 32'h80);
    line_cs = 1'b0;
    n_ack = 0;
    for (int c = 0; c < 20 && n_ack == 0; c++) begin
      @(negedge clk);
      if (line_ack) n_ack++;
    end
    chk("t6_second_ack", n_ack, 1);
    bus_gnt = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
